// File: rtl/period_meter_if.sv
// ---------------------------------------------------------------------------
// period_meter_if
//
// Groups the measured input and the measurement results of period_meter.
//
// Signals:
//   div_in    measured square wave (driven by the source side)
//   period    last completed rising-to-rising period, in clk cycles
//   high_len  high time of that same period, in clk cycles
//   valid     one-cycle pulse when period/high_len update
//   lock      the last LOCK_N valid periods were identical
//   err       sticky: some valid period differed from the expected ratio
//   ovf       counter saturated without seeing a rising edge
//
// Modports:
//   master    source / monitor side: drives div_in, observes results
//   slave     meter side: observes div_in, drives results
// ---------------------------------------------------------------------------
interface period_meter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             div_in;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_len;
    logic             valid;
    logic             lock;
    logic             err;
    logic             ovf;

    modport master (
        output div_in,
        input  period,
        input  high_len,
        input  valid,
        input  lock,
        input  err,
        input  ovf
    );

    modport slave (
        input  div_in,
        output period,
        output high_len,
        output valid,
        output lock,
        output err,
        output ovf
    );
endinterface

// File: rtl/period_meter.sv
// ---------------------------------------------------------------------------
// period_meter
//
// Measures the period and high time of a slow square wave in clk cycles,
// reports each completed period with a one-cycle valid pulse, asserts lock
// after LOCK_N identical periods in a row, and flags (sticky) any period
// that differs from EXPECT. A period that runs past the counter range
// raises ovf until the next valid measurement.
//
// Parameters:
//   WIDTH   width of the counters and of period/high_len (default 8)
//   EXPECT  expected period in clk cycles, 2 .. 2^WIDTH-1 (default 6)
//   LOCK_N  identical periods required for lock, 2 .. 15 (default 3)
//
// Ports:
//   clk     system clock, all state changes on its rising edge
//   rst     synchronous, active-high reset
//   mtr     period_meter_if.slave: div_in in; period, high_len, valid,
//           lock, err, ovf out (all outputs registered)
//
// Configuration macro:
//   PERIOD_METER_SYNC_EN  when defined, div_in passes through a two-flop
//                         synchronizer before edge detection (adds 2 cycles
//                         of latency, for asynchronous sources). When
//                         undefined, div_in must be synchronous to clk.
// ---------------------------------------------------------------------------
module period_meter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned EXPECT = 6,
    parameter int unsigned LOCK_N = 3
) (
    input  logic          clk,
    input  logic          rst,
    period_meter_if.slave mtr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MEAS = 2'd1,
        S_OVF  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] EXPECT_V = WIDTH'(EXPECT);
    localparam logic [3:0]       LOCK_V   = 4'(LOCK_N);

    // -----------------------------------------------------------------------
    // Input conditioning and edge detection
    // -----------------------------------------------------------------------
    logic w_s;
    logic r_s_d;
    logic w_rise;
    logic w_fall;

`ifdef PERIOD_METER_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= mtr.div_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_s = r_sync2;
`else
    assign w_s = mtr.div_in;
`endif

    // History resets to 0, so a source already high when reset releases
    // is seen as a rising edge on the first active cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_d <= 1'b0;
        end else begin
            r_s_d <= w_s;
        end
    end

    assign w_rise = w_s & ~r_s_d;
    assign w_fall = ~w_s & r_s_d;

    // -----------------------------------------------------------------------
    // Measurement state
    // -----------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_period;
    logic [WIDTH-1:0] r_high_len;
    logic             r_valid;
    logic             r_lock;
    logic             r_err;
    logic             r_ovf;
    logic [3:0]       r_match;

    state_t           w_state_n;
    logic [WIDTH-1:0] w_cnt_n;
    logic [WIDTH-1:0] w_hi_n;
    logic [WIDTH-1:0] w_period_n;
    logic [WIDTH-1:0] w_high_len_n;
    logic             w_valid_n;
    logic             w_lock_n;
    logic             w_err_n;
    logic             w_ovf_n;
    logic [3:0]       w_match_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_period   <= '0;
            r_high_len <= '0;
            r_valid    <= 1'b0;
            r_lock     <= 1'b0;
            r_err      <= 1'b0;
            r_ovf      <= 1'b0;
            r_match    <= '0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_hi       <= w_hi_n;
            r_period   <= w_period_n;
            r_high_len <= w_high_len_n;
            r_valid    <= w_valid_n;
            r_lock     <= w_lock_n;
            r_err      <= w_err_n;
            r_ovf      <= w_ovf_n;
            r_match    <= w_match_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_hi_n       = r_hi;
        w_period_n   = r_period;
        w_high_len_n = r_high_len;
        w_valid_n    = 1'b0;
        w_lock_n     = r_lock;
        w_err_n      = r_err;
        w_ovf_n      = r_ovf;
        w_match_n    = r_match;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_n = '0;
                if (w_rise) begin
                    w_state_n = S_MEAS;
                    w_cnt_n   = CNT_ONE;
                end
            end

            S_MEAS: begin
                if (w_rise) begin
                    // Completed period; a rise in the saturating cycle still
                    // counts as a normal measurement.
                    w_period_n   = r_cnt;
                    w_high_len_n = r_hi;
                    w_valid_n    = 1'b1;
                    w_cnt_n      = CNT_ONE;
                    w_ovf_n      = 1'b0;

                    // match is the length of the current run of identical
                    // periods; it saturates at LOCK_N so it cannot wrap.
                    if (r_cnt == r_period) begin
                        if (r_match < LOCK_V) begin
                            w_match_n = r_match + 4'd1;
                        end
                    end else begin
                        w_match_n = 4'd1;
                    end
                    w_lock_n = (w_match_n >= LOCK_V);

                    if (r_cnt != EXPECT_V) begin
                        w_err_n = 1'b1;
                    end
                end else begin
                    if (w_fall) begin
                        w_hi_n = r_cnt;
                    end
                    if (r_cnt == CNT_MAX) begin
                        w_state_n = S_OVF;
                        w_ovf_n   = 1'b1;
                        w_lock_n  = 1'b0;
                        w_match_n = '0;
                    end else begin
                        w_cnt_n = r_cnt + CNT_ONE;
                    end
                end
            end

            S_OVF: begin
                // Counter frozen; the partial period that ends at the next
                // rise is discarded.
                if (w_rise) begin
                    w_state_n = S_MEAS;
                    w_cnt_n   = CNT_ONE;
                end
            end

            default: begin
                w_state_n = S_IDLE;
                w_cnt_n   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs (all registered)
    // -----------------------------------------------------------------------
    assign mtr.period   = r_period;
    assign mtr.high_len = r_high_len;
    assign mtr.valid    = r_valid;
    assign mtr.lock     = r_lock;
    assign mtr.err      = r_err;
    assign mtr.ovf      = r_ovf;

endmodule

// File: tb/tb_period_meter.sv
// ---------------------------------------------------------------------------
// tb_period_meter
//
// Two meters watch the same div_in: dut_a with EXPECT=6, dut_b with EXPECT=8.
// A timestamp-based model predicts every output; a compare process checks
// both DUTs on each falling clk edge, and directed phases add literal checks.
// ---------------------------------------------------------------------------
module tb_period_meter;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned LOCK_N = 3;
    localparam int unsigned MAXCNT = 255;
    localparam int unsigned EXP_A  = 6;
    localparam int unsigned EXP_B  = 8;
`ifdef PERIOD_METER_SYNC_EN
    localparam bit SYNC = 1'b1;
`else
    localparam bit SYNC = 1'b0;
`endif

    logic clk;
    logic rst;
    logic tb_div;
    logic chk_en;

    int checks;
    int errors;
    int vcnt;

    period_meter_if #(.WIDTH(WIDTH)) ifa ();
    period_meter_if #(.WIDTH(WIDTH)) ifb ();

    assign ifa.div_in = tb_div;
    assign ifb.div_in = tb_div;

    period_meter #(.WIDTH(WIDTH), .EXPECT(EXP_A), .LOCK_N(LOCK_N)) dut_a (
        .clk (clk),
        .rst (rst),
        .mtr (ifa)
    );

    period_meter #(.WIDTH(WIDTH), .EXPECT(EXP_B), .LOCK_N(LOCK_N)) dut_b (
        .clk (clk),
        .rst (rst),
        .mtr (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", nm, got, exp);
        end
    endtask

    // ---------------------------------------------------------------------
    // Model: timestamps of sampled edges, periods as timestamp differences.
    // ---------------------------------------------------------------------
    int unsigned n;
    int unsigned t_rise;
    int unsigned t_fall;
    bit          meas;
    logic        last_s;
    logic [1:0]  dly;
    int unsigned hist[$];
    logic [7:0]  e_period;
    logic [7:0]  e_high;
    logic        e_valid;
    logic        e_lock;
    logic        e_ovf;
    logic [1:0]  e_err;

    initial begin
        n = 0; t_rise = 0; t_fall = 0; meas = 0; last_s = 0; dly = '0;
        e_period = '0; e_high = '0; e_valid = 0; e_lock = 0; e_ovf = 0; e_err = '0;
        forever begin
            logic s;
            int unsigned p;
            bit same;
            @(posedge clk);
            if (rst) begin
                meas = 0; last_s = 0; dly = '0; hist.delete();
                e_period = '0; e_high = '0; e_valid = 0; e_lock = 0; e_ovf = 0; e_err = '0;
            end else begin
                n++;
                s   = SYNC ? dly[1] : tb_div;
                dly = {dly[0], tb_div};
                e_valid = 0;
                if (s && !last_s) begin
                    if (meas) begin
                        p        = n - t_rise;
                        e_period = 8'(p);
                        e_high   = 8'(t_fall - t_rise);
                        e_valid  = 1;
                        e_ovf    = 0;
                        hist.push_back(p);
                        if (hist.size() > LOCK_N) void'(hist.pop_front());
                        same = (hist.size() == LOCK_N);
                        foreach (hist[i]) if (hist[i] != p) same = 0;
                        e_lock = same;
                        if (p != EXP_A) e_err[0] = 1;
                        if (p != EXP_B) e_err[1] = 1;
                    end
                    meas   = 1;
                    t_rise = n;
                end else begin
                    if (meas && !s && last_s) t_fall = n;
                    if (meas && (n - t_rise) >= MAXCNT) begin
                        meas   = 0;
                        e_ovf  = 1;
                        e_lock = 0;
                        hist.delete();
                    end
                end
                last_s = s;
            end
        end
    end

    // Compare process: every cycle, both DUTs against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("a.period",   ifa.period,   e_period);
            chk("a.high_len", ifa.high_len, e_high);
            chk("a.valid",    ifa.valid,    e_valid);
            chk("a.lock",     ifa.lock,     e_lock);
            chk("a.err",      ifa.err,      e_err[0]);
            chk("a.ovf",      ifa.ovf,      e_ovf);
            chk("b.period",   ifb.period,   e_period);
            chk("b.high_len", ifb.high_len, e_high);
            chk("b.valid",    ifb.valid,    e_valid);
            chk("b.lock",     ifb.lock,     e_lock);
            chk("b.err",      ifb.err,      e_err[1]);
            chk("b.ovf",      ifb.ovf,      e_ovf);
        end
    end

    initial begin
        vcnt = 0;
        forever begin
            @(negedge clk);
            if (ifa.valid === 1'b1) vcnt++;
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers: each level lasts n rising clk edges.
    // ---------------------------------------------------------------------
    task automatic hold(input logic v, input int cyc);
        tb_div = v;
        repeat (cyc) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int h, input int l, input int np);
        repeat (np) begin
            hold(1'b1, h);
            hold(1'b0, l);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".period"},   ifa.period,   0);
        chk({tag, ".high_len"}, ifa.high_len, 0);
        chk({tag, ".valid"},    ifa.valid,    0);
        chk({tag, ".lock"},     ifa.lock,     0);
        chk({tag, ".err"},      ifa.err,      0);
        chk({tag, ".ovf"},      ifa.ovf,      0);
        chk({tag, ".b_err"},    ifb.err,      0);
    endtask

    int v0;

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        tb_div = 1'b0;
        rst    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        chk_zero("rst");

        // Divide-by-6: 4 valids, locked, no error on dut_a.
        v0 = vcnt;
        hold(1'b0, 2);
        drive(3, 3, 4);
        hold(1'b1, 4);
        chk("d6.nvalid",   vcnt - v0,    4);
        chk("d6.period",   ifa.period,   6);
        chk("d6.high_len", ifa.high_len, 3);
        chk("d6.lock",     ifa.lock,     1);
        chk("d6.err",      ifa.err,      0);
        chk("d6.b_err",    ifb.err,      1);

        // One 4/4 period while locked at 6.
        hold(1'b0, 4);
        hold(1'b1, 4);
        chk("odd.period",   ifa.period,   8);
        chk("odd.high_len", ifa.high_len, 4);
        chk("odd.lock",     ifa.lock,     0);
        chk("odd.err",      ifa.err,      1);

        // Three more periods of 6 relock; err stays.
        hold(1'b0, 2);
        drive(3, 3, 2);
        hold(1'b1, 4);
        chk("relock.period", ifa.period, 6);
        chk("relock.lock",   ifa.lock,   1);
        chk("relock.err",    ifa.err,    1);

        // Ring-counter wave against EXPECT=8.
        pulse_rst();
        hold(1'b0, 2);
        drive(4, 4, 4);
        hold(1'b1, 4);
        chk("ring.period",   ifb.period,   8);
        chk("ring.high_len", ifb.high_len, 4);
        chk("ring.lock",     ifb.lock,     1);
        chk("ring.err",      ifb.err,      0);

        // Long low: saturation.
        v0 = vcnt;
        hold(1'b0, 300);
        chk("ovf.ovf",    ifa.ovf,   1);
        chk("ovf.lock",   ifa.lock,  0);
        chk("ovf.b_ovf",  ifb.ovf,   1);
        chk("ovf.nvalid", vcnt - v0, 0);
        hold(1'b1, 3);
        hold(1'b0, 3);
        hold(1'b1, 4);
        chk("ovfx.nvalid",   vcnt - v0,    1);
        chk("ovfx.ovf",      ifa.ovf,      0);
        chk("ovfx.period",   ifa.period,   6);
        chk("ovfx.high_len", ifa.high_len, 3);

        // Lock again, then reset mid-period with div_in high.
        hold(1'b0, 2);
        drive(3, 3, 2);
        hold(1'b1, 4);
        chk("pre_rst.lock", ifa.lock, 1);
        pulse_rst();
        chk_zero("mid_rst");
        v0 = vcnt;
        hold(1'b1, 2);
        hold(1'b0, 3);
        hold(1'b1, 4);
        chk("post_rst.nvalid",   vcnt - v0,    1);
        chk("post_rst.period",   ifa.period,   5);
        chk("post_rst.high_len", ifa.high_len, 2);

        // 1-cycle high pulse every 6 cycles.
        hold(1'b0, 2);
        drive(1, 5, 4);
        hold(1'b1, 1);
        hold(1'b0, 4);
        chk("pulse.period",   ifa.period,   6);
        chk("pulse.high_len", ifa.high_len, 1);
        chk("pulse.lock",     ifa.lock,     1);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
